// File: rtl/zrb_spi_clk_ctrl_if.sv
// zrb_spi_clk_ctrl_if: request/status bundle between the SPI clock controller, its requester and its clock generator.
interface zrb_spi_clk_ctrl_if;
    logic init_start;
    logic speed_full_req;
    logic cs_assert;
    logic xfer_req;
    logic gen_clk;
    logic gen_reset;
    logic gen_full_speed;
    logic cs_n;
    logic sclk_rise;
    logic sclk_fall;
    logic xfer_ack;
    logic init_done;
    logic busy;
    logic timeout_err;
    modport master (
        output init_start, speed_full_req, cs_assert, xfer_req, gen_clk,
        input  gen_reset, gen_full_speed, cs_n, sclk_rise, sclk_fall, xfer_ack, init_done, busy, timeout_err
    );
    modport slave (
        input  init_start, speed_full_req, cs_assert, xfer_req, gen_clk,
        output gen_reset, gen_full_speed, cs_n, sclk_rise, sclk_fall, xfer_ack, init_done, busy, timeout_err
    );
endinterface

// File: rtl/zrb_spi_clk_ctrl.sv
// zrb_spi_clk_ctrl: SPI SCLK sequencing for card init, speed switching and byte transfers.
// Define ZRB_SPI_CLK_CTRL_TIMEOUT_EN to add the stalled-generator watchdog.
module zrb_spi_clk_ctrl #(
    parameter int DUMMY_CLKS  = 80,
    parameter int BYTE_CLKS   = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic clk,
    input logic reset_n,
    zrb_spi_clk_ctrl_if.slave bus
);
    localparam int MAXC = DUMMY_CLKS > BYTE_CLKS ? DUMMY_CLKS : BYTE_CLKS;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, INIT, READY, XFER, SPDSW} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, tgt;
    logic gen_clk_q, spd_q, spd_d;
    logic gen_reset_q, gen_reset_d, fs_q, fs_d, cs_n_q, cs_n_d;
    logic rise_q, rise_d, fall_q, fall_d, ack_q, ack_d;
    logic done_q, done_d, busy_q, busy_d, to_q, to_d;
    logic rise, fall, active, last_fall, spd_chg, to_hit;

    assign rise      = bus.gen_clk & ~gen_clk_q;
    assign fall      = ~bus.gen_clk & gen_clk_q;
    assign active    = state_q == INIT || state_q == XFER;
    assign tgt       = state_q == INIT ? CW'(DUMMY_CLKS) : CW'(BYTE_CLKS);
    assign last_fall = fall && cnt_q == tgt;
    assign spd_chg   = bus.speed_full_req != fs_q;

`ifdef ZRB_SPI_CLK_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_q, wd_d;
    assign wd_d   = (active && !rise && !fall) ? wd_q + 1'b1 : '0;
    assign to_hit = wd_d == WW'(TIMEOUT_CYC);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) wd_q <= '0;
        else wd_q <= wd_d;
`else
    // never true; without the watchdog INIT/XFER wait for the generator indefinitely
    assign to_hit = TIMEOUT_CYC < 0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gen_clk_q   <= 1'b0;
            spd_q       <= 1'b0;
            gen_reset_q <= 1'b1;
            fs_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gen_clk_q   <= bus.gen_clk;
            spd_q       <= spd_d;
            gen_reset_q <= gen_reset_d;
            fs_q        <= fs_d;
            cs_n_q      <= cs_n_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            to_q        <= to_d;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.init_start ? INIT : IDLE;
            INIT:    state_d = to_hit ? IDLE : last_fall ? READY : INIT;
            READY:   state_d = bus.init_start ? INIT : spd_chg ? SPDSW : bus.xfer_req ? XFER : READY;
            XFER:    state_d = to_hit ? IDLE : last_fall ? READY : XFER;
            SPDSW:   state_d = spd_q ? READY : SPDSW;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gen_reset_d = gen_reset_q;
        fs_d        = fs_q;
        cs_n_d      = cs_n_q;
        done_d      = done_q;
        cnt_d       = cnt_q;
        spd_d       = 1'b0;
        ack_d       = 1'b0;
        rise_d      = rise & active;
        fall_d      = fall & active;
        to_d        = to_hit;
        busy_d      = state_d != IDLE && state_d != READY;
        case (state_q)
            IDLE: begin
                gen_reset_d = ~bus.init_start;
                cs_n_d      = 1'b1;
                fs_d        = 1'b0;
                cnt_d       = '0;
            end
            INIT, XFER: begin
                cnt_d  = (rise && cnt_q != tgt) ? cnt_q + 1'b1 : cnt_q;
                cs_n_d = state_q == XFER ? ~bus.cs_assert : 1'b1;
                if (last_fall) begin
                    gen_reset_d = 1'b1;
                    done_d      = done_q | (state_q == INIT);
                    ack_d       = state_q == XFER;
                end
                if (to_hit) begin
                    gen_reset_d = 1'b1;
                    cs_n_d      = 1'b1;
                    done_d      = 1'b0;
                end
            end
            READY: begin
                gen_reset_d = 1'b1;
                cs_n_d      = ~bus.cs_assert;
                if (bus.init_start) begin
                    gen_reset_d = 1'b0;
                    cs_n_d      = 1'b1;
                    done_d      = 1'b0;
                    fs_d        = 1'b0;
                    cnt_d       = '0;
                end else if (spd_chg) begin
                    // speed only moves while the generator is held in reset
                    fs_d = bus.speed_full_req;
                end else if (bus.xfer_req) begin
                    gen_reset_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            SPDSW: begin
                gen_reset_d = 1'b1;
                spd_d       = ~spd_q;
            end
            default: gen_reset_d = 1'b1;
        endcase
    end

    assign bus.gen_reset      = gen_reset_q;
    assign bus.gen_full_speed = fs_q;
    assign bus.cs_n           = cs_n_q;
    assign bus.sclk_rise      = rise_q;
    assign bus.sclk_fall      = fall_q;
    assign bus.xfer_ack       = ack_q;
    assign bus.init_done      = done_q;
    assign bus.busy           = busy_q;
    assign bus.timeout_err    = to_q;
endmodule

// File: doc/zrb_spi_clk_ctrl.md
ZRB_SPI_CLK_CTRL -- requirements
Module: zrb_spi_clk_ctrl

Interface
REQ-001 Parameter DUMMY_CLKS, default 80: SCLK periods emitted at low speed with cs_n high during init.
REQ-002 Parameter BYTE_CLKS, default 8: SCLK periods per transfer.
REQ-003 Parameter TIMEOUT_CYC, default 65535: max clk cycles without a gen_clk edge (Configuration only).
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 init_start  in  1  pulse: start card init sequence.
REQ-007 speed_full_req  in  1  level: 1 = full speed wanted, 0 = low speed wanted.
REQ-008 cs_assert  in  1  level: requester wants chip select active.
REQ-009 xfer_req  in  1  level: request one BYTE_CLKS-period transfer.
REQ-010 gen_clk  in  1  clock-generator output, clk-synchronous.
REQ-011 gen_reset  out  1  generator reset; 1 holds SCLK low and phase cleared.
REQ-012 gen_full_speed  out  1  generator speed select (drives low_full_speed).
REQ-013 cs_n  out  1  registered chip select, active low.
REQ-014 sclk_rise, sclk_fall  out  1 each  one-cycle pulses on gen_clk edges, valid only in INIT/XFER.
REQ-015 xfer_ack  out  1  one-cycle pulse: transfer finished, SCLK stopped low.
REQ-016 init_done  out  1  level: init completed, READY reachable.
REQ-017 busy  out  1  1 in any state except IDLE and READY.
REQ-018 timeout_err  out  1  one-cycle pulse on watchdog expiry (Configuration only, else tied 0).

Function
REQ-019 States: IDLE, INIT, READY, XFER, SPDSW; all outputs registered.
REQ-020 Edge detect: gen_clk registered once; rise = gen_clk & ~gen_clk_q, fall = ~gen_clk & gen_clk_q; 1-cycle latency.
REQ-021 IDLE: gen_reset=1, cs_n=1; init_start -> INIT, gen_full_speed<=0, gen_reset<=0, edge counter<=0.
REQ-022 INIT: cs_n=1, count rises; after DUMMY_CLKS-th rise, on next fall assert gen_reset, set init_done, -> READY.
REQ-023 READY: gen_reset=1, SCLK low; cs_n <= ~cs_assert every cycle.
REQ-024 READY priority: init_start > speed change > xfer_req; speed change = speed_full_req != gen_full_speed.
REQ-025 READY init_start: init_done<=0, gen_full_speed<=0, -> INIT (re-init).
REQ-026 SPDSW: gen_reset held 1 for 2 cycles; gen_full_speed updated in first cycle; -> READY; never changes speed while gen_reset=0.
REQ-027 READY xfer_req: gen_reset<=0, counter<=0, -> XFER; cs_n keeps following cs_assert.
REQ-028 XFER: after BYTE_CLKS-th rise, on next fall assert gen_reset, pulse xfer_ack, -> READY.
REQ-029 xfer_req sampled only in READY; held high through ack gives back-to-back transfers with one READY cycle gap.
REQ-030 Counter width clog2(max(DUMMY_CLKS,BYTE_CLKS)+1); no wrap within a sequence.
REQ-031 init_start in INIT, XFER or SPDSW ignored; cs_assert changes in INIT ignored.

Reset
REQ-032 reset_n low: state IDLE, gen_reset=1, gen_full_speed=0, cs_n=1, init_done=0, busy=0, all pulses 0, counters and gen_clk_q 0.
REQ-033 Reset mid-INIT/XFER aborts immediately; no xfer_ack issued; first post-reset action requires init_start.

Configuration
REQ-034 Macro ZRB_SPI_CLK_CTRL_TIMEOUT_EN defined: watchdog counts clk cycles in INIT/XFER, cleared on any edge; reaching TIMEOUT_CYC pulses timeout_err, gen_reset<=1, cs_n<=1, init_done<=0, -> IDLE.
REQ-035 Macro undefined: no watchdog logic, timeout_err constant 0, INIT/XFER wait indefinitely.

Verification
REQ-036 reset_n low then init_start with generator model -> exactly 80 rises with cs_n=1, gen_reset=1 after 80th fall, init_done=1.
REQ-037 READY, cs_assert=1, xfer_req=1 for one byte -> cs_n=0, 8 sclk_rise pulses, one xfer_ack, SCLK low after.
REQ-038 READY, speed_full_req=1 and xfer_req=1 same cycle -> SPDSW first (gen_reset=1 2 cycles, gen_full_speed=1), then transfer at full speed.
REQ-039 reset_n low after 3rd rise of XFER -> all outputs at reset values within same cycle, no xfer_ack.
REQ-040 TIMEOUT_EN defined, gen_clk stuck 0 in XFER -> timeout_err pulse after 65535 cycles, state IDLE, cs_n=1; undefined: stays XFER.
